// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// operand_loader: byte-stream operand loader and result unloader for an adder
// Revision: 1.0
// ============================================================================
module operand_loader #(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sayi1,
  output logic [WIDTH-1:0] sayi2,
  input  logic [WIDTH-1:0] toplam,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int c_nbytes = WIDTH / 8;
  localparam int c_cnt_w  = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;
  localparam logic [c_cnt_w-1:0] c_last_byte   = c_cnt_w'(c_nbytes - 1);
  localparam logic [7:0]         c_settle_last = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]         settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0]   sayi1_q, sayi1_d;
  logic [WIDTH-1:0]   sayi2_q, sayi2_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [c_cnt_w+2:0] bit_idx;
  logic               in_fire;
  logic               out_fire;
  logic               last_byte;

  assign bit_idx   = {byte_cnt_q, 3'b000};
  assign in_ready  = rst_n && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SETTLE) || (state_q == SEND);
  // result_q is cleared by reset, so out_data also reads zero after reset.
  assign out_data  = result_q[bit_idx +: 8];
  assign sayi1     = sayi1_q;
  assign sayi2     = sayi2_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_byte = (byte_cnt_q == c_last_byte);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    sayi1_d      = sayi1_q;
    sayi2_d      = sayi2_q;
    result_d     = result_q;
    case (state_q)
      LOAD_A: begin
        if (in_fire) begin
          sayi1_d[bit_idx +: 8] = in_data;
          if (last_byte) begin
            state_d    = LOAD_B;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + c_cnt_w'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_fire) begin
          sayi2_d[bit_idx +: 8] = in_data;
          if (last_byte) begin
            state_d      = SETTLE;
            byte_cnt_d   = '0;
            settle_cnt_d = 8'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + c_cnt_w'(1);
          end
        end
      end
      SETTLE: begin
        // Operands have been stable since entry; sample the adder at the end of the window.
        if (settle_cnt_q == c_settle_last) begin
          result_d   = toplam;
          state_d    = SEND;
          byte_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (last_byte) begin
            state_d    = LOAD_A;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + c_cnt_w'(1);
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD_A;
      byte_cnt_q   <= '0;
      settle_cnt_q <= 8'd0;
      sayi1_q      <= '0;
      sayi2_q      <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      sayi1_q      <= sayi1_d;
      sayi2_q      <= sayi2_d;
      result_q     <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_operand_loader: randomized self-checking bench for operand_loader
// Revision: 1.0
// ============================================================================
module tb_operand_loader;

  localparam int WIDTH         = 64;
  localparam int SETTLE_CYCLES = 2;
  localparam int c_nbytes      = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sayi1;
  logic [WIDTH-1:0] sayi2;
  logic [WIDTH-1:0] toplam;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  operand_loader #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sayi1     (sayi1),
    .sayi2     (sayi2),
    .toplam    (toplam),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Combinational adder standing in for the real adder variants.
  assign toplam = sayi1 + sayi2;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; abort_at >= 0 pulses reset after that many result bytes left.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input bit stall, input int abort_at);
    logic [7:0]  ibytes[$];
    logic [63:0] exp_sum;
    int          idx;
    int          k;
    int          guard;
    bit          fire;
    for (int i = 0; i < c_nbytes; i++) ibytes.push_back(a[8*i +: 8]);
    for (int i = 0; i < c_nbytes; i++) ibytes.push_back(b[8*i +: 8]);
    exp_sum = a + b;
    idx   = 0;
    guard = 0;
    while (idx < 2 * c_nbytes) begin
      in_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = in_valid ? ibytes[idx] : 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid !== 1'b0 || in_ready !== 1'b1) check("load_handshake", {out_valid, in_ready}, 64'h1);
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        if (idx == 0) check("first_byte_lsb", {56'h0, sayi1[7:0]}, {56'h0, a[7:0]});
        idx++;
      end
      if (++guard > 2000) begin
        check("load_timeout", 64'(idx), 64'(2 * c_nbytes));
        return;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("sayi1", sayi1, a);
    check("sayi2", sayi2, b);
    check("busy_settle", {63'h0, busy}, 64'h1);
    for (int c = 1; c < SETTLE_CYCLES; c++) begin
      check("early_out_valid", {63'h0, out_valid}, 64'h0);
      tick();
    end
    check("out_valid_latency", {63'h0, out_valid}, 64'h0);
    tick();
    check("out_valid_rise", {63'h0, out_valid}, 64'h1);
    k     = 0;
    guard = 0;
    while (k < c_nbytes) begin
      if (k == abort_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rst_n     = 1'b0;
        tick();
        check("abort_out_valid", {63'h0, out_valid}, 64'h0);
        check("abort_in_ready", {63'h0, in_ready}, 64'h0);
        check("abort_sayi", sayi1 | sayi2, 64'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("abort_release_ready", {63'h0, in_ready}, 64'h1);
        return;
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      // A stalled byte is rechecked on the next cycle, so this also covers stability.
      check("out_valid", {63'h0, out_valid}, 64'h1);
      check("out_byte", {56'h0, out_data}, {56'h0, exp_sum[8*k +: 8]});
      check("send_in_ready", {63'h0, in_ready}, 64'h0);
      fire = out_ready;
      tick();
      if (fire) k++;
      if (++guard > 2000) begin
        check("send_timeout", 64'(k), 64'(c_nbytes));
        return;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("no_extra_byte", {63'h0, out_valid}, 64'h0);
    check("idle_ready", {62'h0, busy, in_ready}, 64'h1);
    check("operands_hold", sayi1 ^ sayi2, a ^ b);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", {63'h0, in_ready}, 64'h0);
      check("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_sayi1", sayi1, 64'h0);
      check("rst_sayi2", sayi2, 64'h0);
      check("rst_out_data", {56'h0, out_data}, 64'h0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;

    run_op(64'h0000000000000005, 64'h0000000000000003, 1'b0, -1);
    run_op(64'h0123456789ABCDEF, 64'h0, 1'b0, -1);
    run_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (n % 25 == 0) a = '1;
      if (n % 30 == 0) b = 64'h1;
      run_op(a, b, 1'b1, -1);
    end

    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3);
    run_op(64'h8000000000000000, 64'h8000000000000001, 1'b1, -1);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
